request_encoder: RTL and testbench
==================================

Name: request_encoder

Overview:
- 4-to-2 request encoder with a sequential handshake: the inverse of the team's 2-to-4 address decoder.
- Samples four request lines and selects one, by fixed or round-robin priority.
- Presents the selected index as addr0/addr1 with enable asserted, and holds it until the consumer accepts.
- Its outputs drive the decoder's addr0/addr1/enable inputs directly.

Parameters:
- RR_MODE, 1, 1 = round-robin priority; 0 = fixed priority (in0 highest, in3 lowest).
- COUNT_WIDTH, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in0  input  1  request line 0 (level-sensitive).
- in1  input  1  request line 1.
- in2  input  1  request line 2.
- in3  input  1  request line 3.
- ready  input  1  consumer accepts the presented index this cycle.
- addr0  output  1  LSB of the selected index.
- addr1  output  1  MSB of the selected index.
- enable  output  1  valid: addr0/addr1 hold a selected index.
- count  output  COUNT_WIDTH  number of accepted transfers since reset.

Behaviour:
- Reset: one clock with reset=1 sets state=IDLE, addr0=0, addr1=0, enable=0, count=0, and rr pointer last=3, so the first search starts at index 0.
- Reset mid-transfer abandons the presented index; no handshake is counted for that cycle.
- States:
  - IDLE: enable=0.
  - PRESENT: enable=1.
- Selection, combinational from the current in0..in3:
  - RR_MODE=1: search indices last+1, last+2, ... mod 4; the first asserted line wins.
  - RR_MODE=0: lowest asserted index wins; last is ignored.
- Index encoding: index = {addr1, addr0}, e.g. in2 -> addr1=1, addr0=0. Decoding this pair yields a one-hot equal to the selected request.
- IDLE -> PRESENT:
  - If any request is asserted at a rising edge, register the selected index and go to PRESENT.
  - Latency is 1 cycle: enable rises the cycle after the request is first seen.
  - With no request, stay in IDLE; addr0/addr1 keep their last values, which are don't-care while enable=0.
- PRESENT hold:
  - While ready=0, addr0, addr1 and enable stay stable.
  - Input changes are ignored, including retraction of the selected request (no retraction allowed).
- Handshake: a rising edge with enable=1 and ready=1 has these effects:
  - count increments, wrapping modulo 2^COUNT_WIDTH (all ones -> 0).
  - last is set to the presented index.
  - Using the updated last, selection is re-evaluated on the current inputs:
    - If any request is asserted, load the new index and stay in PRESENT (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Simultaneous requests: exactly one is chosen per handshake. Under RR_MODE=1, four permanently asserted lines are granted 0,1,2,3,0,... with no starvation.
- ready while in IDLE is ignored.
- No X on outputs after the first reset clock.

Decomposition:
- Shared include encoder_defs.vh holds:
  - state encodings: IDLE=1'b0, PRESENT=1'b1.
  - number of lines NUM_REQ=4.
  - the reset value of the pointer, LAST_RESET=2'd3.
- Sub-module rr_select: purely combinational.
  - Inputs: in0..in3, last[1:0], rr_mode.
  - Outputs: sel[1:0], any.
  - It is tested standalone with an exhaustive truth-table bench (16 request patterns × 4 pointers × 2 modes).
- request_encoder contains only the state register, output registers, pointer and counter.

Test Plan:
- Reset then single request: in2=1 held, ready=0 for 3 cycles -> enable=1 one cycle after in2 is seen; addr1=1, addr0=0 stable for all 3 cycles; count=0. Then ready=1 -> count=1. With in2 dropped, enable=0 next cycle.
- Round-robin fairness, RR_MODE=1: in0..in3 all =1, ready=1 constant -> indices 0,1,2,3,0,1 on consecutive cycles with no bubble; count=6 after 6 handshakes.
- Fixed priority, RR_MODE=0: in1=1 and in3=1, ready=1 -> index 1 repeated every cycle; in3 is never granted while in1 is asserted.
- Hold under backpressure: in0 selected with ready=0, then in0 dropped and in3 raised for 2 cycles -> addr stays 00 and enable=1. Then ready=1 -> next index is 3.
- Counter wrap: COUNT_WIDTH=2, 5 handshakes -> count sequence 1,2,3,0,1.
- Reset mid-transfer: enable=1 with addr=10, assert reset with ready=1 in the same cycle -> next cycle enable=0, count unchanged at 0, pointer back to 3. The first grant after reset with all requests asserted is index 0.
- End-to-end: encoder outputs wired to the decoder; for each single-hot input pattern, the decoder one-hot output equals the input pattern while enable=1.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// Shared definitions for the request encoder: state encoding, request count
// and the round-robin pointer reset value.
package request_encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;

    // Pointer starts at the top index so the first search begins at index 0.
    localparam logic [1:0] LAST_RESET = 2'd3;

endpackage

// File: rtl/request_encoder_rr_select.sv
// Combinational request selector: round-robin after 'last', or fixed
// lowest-index-wins priority when rr_mode is low.
module rr_select
    import request_encoder_pkg::*;
(
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic [1:0] last,
    input  logic       rr_mode,
    output logic [1:0] sel,
    output logic       any
);

    logic [NUM_REQ-1:0] req;
    logic [1:0]         start;
    logic [NUM_REQ-1:0] rot;

    assign req   = {in3, in2, in1, in0};
    assign start = rr_mode ? last + 2'd1 : 2'd0;
    assign any   = |req;

    // rot[gi] is the request that sits gi places after the search start.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = req[start + 2'(gi)];
        end
    endgenerate

    always_comb begin
        sel = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel = start + 2'(k);
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// 4-to-2 request encoder with a valid/ready hold: grants one request line,
// presents its index on addr1/addr0 and keeps it until the consumer accepts.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int RR_MODE     = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in0,
    input  logic                   in1,
    input  logic                   in2,
    input  logic                   in3,
    input  logic                   ready,
    output logic                   addr0,
    output logic                   addr1,
    output logic                   enable,
    output logic [COUNT_WIDTH-1:0] count
);

    state_t                 state_reg, state_next;
    logic [1:0]             addr_reg, addr_next;
    logic [1:0]             last_reg, last_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;

    // Selector 0 searches from the stored pointer (idle grant); selector 1
    // searches from the index being accepted, i.e. the pointer after a handshake.
    logic [1:0] sel_last [2];
    logic [1:0] sel      [2];
    logic       any      [2];

    assign sel_last[0] = last_reg;
    assign sel_last[1] = addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sel
            rr_select u_rr_select (
                .in0     (in0),
                .in1     (in1),
                .in2     (in2),
                .in3     (in3),
                .last    (sel_last[gi]),
                .rr_mode (RR_MODE != 0),
                .sel     (sel[gi]),
                .any     (any[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            last_reg  <= LAST_RESET;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            last_reg  <= last_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        last_next  = last_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (any[0]) begin
                    addr_next  = sel[0];
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // Inputs are ignored until the consumer accepts.
                if (ready) begin
                    count_next = count_reg + COUNT_WIDTH'(1);
                    last_next  = addr_reg;
                    if (any[1]) begin
                        addr_next  = sel[1];
                        state_next = PRESENT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign addr0  = addr_reg[0];
    assign addr1  = addr_reg[1];
    assign enable = (state_reg == PRESENT);
    assign count  = count_reg;

endmodule

// File: tb/tb_request_encoder.sv
// Directed scoreboard bench for request_encoder: round-robin, fixed-priority
// and narrow-counter instances share one stimulus stream.
module tb_request_encoder;

    logic clk = 1'b0;
    logic reset;
    logic in0, in1, in2, in3, ready;

    logic       a_addr0, a_addr1, a_en;
    logic [7:0] a_cnt;
    logic       f_addr0, f_addr1, f_en;
    logic [7:0] f_cnt;
    logic       w_addr0, w_addr1, w_en;
    logic [1:0] w_cnt;

    int compared   = 0;
    int mismatched = 0;

    localparam int DUT_RR = 0;
    localparam int DUT_FX = 1;
    localparam int DUT_WR = 2;

    always #5 clk = ~clk;

    request_encoder #(.RR_MODE(1), .COUNT_WIDTH(8)) u_rr (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ready(ready), .addr0(a_addr0), .addr1(a_addr1), .enable(a_en), .count(a_cnt)
    );

    request_encoder #(.RR_MODE(0), .COUNT_WIDTH(8)) u_fx (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ready(ready), .addr0(f_addr0), .addr1(f_addr1), .enable(f_en), .count(f_cnt)
    );

    request_encoder #(.RR_MODE(1), .COUNT_WIDTH(2)) u_wr (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ready(ready), .addr0(w_addr0), .addr1(w_addr1), .enable(w_en), .count(w_cnt)
    );

    typedef struct {
        string      tag;
        int         dut;
        logic [10:0] val;   // {enable, addr[1:0], count[7:0]}
    } exp_t;

    exp_t sb[$];

    function automatic logic [10:0] observe(input int dut);
        case (dut)
            DUT_RR:  return {a_en, a_addr1, a_addr0, a_cnt};
            DUT_FX:  return {f_en, f_addr1, f_addr0, f_cnt};
            default: return {w_en, w_addr1, w_addr0, 6'd0, w_cnt};
        endcase
    endfunction

    // Queue the expected post-edge outputs; the wrap instance counts modulo 4.
    task automatic expect_out(input string tag, input int dut, input logic en,
                              input logic [1:0] addr, input int cnt);
        exp_t e;
        int   c;
        c     = (dut == DUT_WR) ? (cnt % 4) : (cnt % 256);
        e.tag = tag;
        e.dut = dut;
        e.val = {en, addr, 8'(c)};
        sb.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic rdy);
        reset = rst;
        {in3, in2, in1, in0} = req;
        ready = rdy;
    endtask

    // Advance one clock and retire every queued expectation.
    task automatic step();
        exp_t        e;
        logic [10:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.dut);
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed en/addr/cnt=%b/%b/%0d expected %b/%b/%0d",
                       e.tag, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
            end
        end
    endtask

    task automatic check_onehot(input string tag, input logic [3:0] req);
        logic [3:0] dec_a, dec_f;
        dec_a = a_en ? (4'b0001 << {a_addr1, a_addr0}) : 4'b0000;
        dec_f = f_en ? (4'b0001 << {f_addr1, f_addr0}) : 4'b0000;
        compared++;
        assert (dec_a === req) else begin
            mismatched++;
            $error("FAIL %s_rr: observed onehot=%b expected %b", tag, dec_a, req);
        end
        compared++;
        assert (dec_f === req) else begin
            mismatched++;
            $error("FAIL %s_fx: observed onehot=%b expected %b", tag, dec_f, req);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0);
        for (int d = 0; d < 3; d++) expect_out("reset", d, 1'b0, 2'd0, 0);
        step();
    endtask

    initial begin
        logic [1:0] rr_seq [7];
        logic [1:0] alt    [4];
        logic [3:0] hot;
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        alt    = '{2'd1, 2'd3, 2'd1, 2'd3};

        do_reset();

        // Single request held under backpressure, then accepted and dropped.
        drive(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 3; d++) expect_out("single_hold", d, 1'b1, 2'd2, 0);
            step();
        end
        drive(1'b0, 4'b0000, 1'b1);
        for (int d = 0; d < 3; d++) expect_out("single_accept", d, 1'b0, 2'd2, 1);
        step();
        drive(1'b0, 4'b0000, 1'b0);
        for (int d = 0; d < 3; d++) expect_out("single_idle", d, 1'b0, 2'd2, 1);
        step();

        // All four lines with ready held: round-robin vs fixed, count wraps at 4.
        do_reset();
        drive(1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 7; i++) begin
            expect_out("rr_fair", DUT_RR, 1'b1, rr_seq[i], i);
            expect_out("rr_wrap", DUT_WR, 1'b1, rr_seq[i], i);
            expect_out("fx_all", DUT_FX, 1'b1, 2'd0, i);
            step();
        end

        // in1 and in3: fixed always grants 1, round-robin alternates.
        do_reset();
        drive(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_out("fx_prio", DUT_FX, 1'b1, 2'd1, i);
            expect_out("rr_alt", DUT_RR, 1'b1, alt[i], i);
            step();
        end

        // Presented index held while inputs change under backpressure.
        do_reset();
        drive(1'b0, 4'b0001, 1'b0);
        for (int d = 0; d < 3; d++) expect_out("bp_grant", d, 1'b1, 2'd0, 0);
        step();
        drive(1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < 3; d++) expect_out("bp_hold", d, 1'b1, 2'd0, 0);
            step();
        end
        drive(1'b0, 4'b1000, 1'b1);
        for (int d = 0; d < 3; d++) expect_out("bp_next", d, 1'b1, 2'd3, 1);
        step();
        drive(1'b0, 4'b0000, 1'b1);
        for (int d = 0; d < 3; d++) expect_out("bp_done", d, 1'b0, 2'd3, 2);
        step();

        // Reset while presenting with ready high: nothing counted, pointer restored.
        do_reset();
        drive(1'b0, 4'b0100, 1'b0);
        for (int d = 0; d < 3; d++) expect_out("mid_grant", d, 1'b1, 2'd2, 0);
        step();
        drive(1'b1, 4'b0100, 1'b1);
        for (int d = 0; d < 3; d++) expect_out("mid_reset", d, 1'b0, 2'd0, 0);
        step();
        drive(1'b0, 4'b1111, 1'b1);
        for (int d = 0; d < 3; d++) expect_out("mid_first", d, 1'b1, 2'd0, 0);
        step();

        // End-to-end through a 2-to-4 decode of the presented index.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            hot = 4'b0001 << k;
            drive(1'b0, hot, 1'b0);
            for (int d = 0; d < 3; d++) expect_out("e2e_grant", d, 1'b1, 2'(k), 0);
            step();
            check_onehot("e2e_onehot", hot);
            drive(1'b0, 4'b0000, 1'b1);
            for (int d = 0; d < 3; d++) expect_out("e2e_accept", d, 1'b0, 2'(k), 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
